store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Queues committed stores from the MEM stage and drains them one byte per accepted cycle into the memory controller's byte-wide write port.
- Lets the pipeline retire a store in one cycle instead of stalling for 1–4 RAM write cycles.
- Provides a load-hazard check so a load is held off while it overlaps any buffered store.

Parameters:
DEPTH, 4, number of store entries; must be a power of two, at least 2
PTR_WIDTH, 2, log2(DEPTH)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
st_valid  input  1  store request from MEM stage
st_addr  input  32  byte address of the store
st_data  input  32  store data, little-endian, low bytes significant
st_length  input  3  store size in bytes: 1, 2 or 4
st_ready  output  1  buffer can accept a store this cycle
ld_valid  input  1  MEM stage wants to issue a load
ld_addr  input  32  load byte address
ld_length  input  3  load size in bytes: 1, 2 or 4
ld_conflict  output  1  load overlaps a buffered store; load must wait
empty  output  1  no stores pending
w_req  output  1  write request to memory controller (drives mem_write)
w_addr  output  32  byte address being written
w_data  output  8  byte being written
w_success  input  1  controller accepted the byte this cycle (mem_w_success)

Behaviour:
- Reset is clock-edge synchronous and has priority over all other events. It clears head, tail, count and byte_idx, and discards all entries.
- After reset: st_ready=1, empty=1, w_req=0, ld_conflict=0. w_addr and w_data are don't-care while w_req=0.
- Reset during a partially drained store leaves RAM partially written; this is accepted behaviour.
- Storage is a circular FIFO of DEPTH entries {addr[31:0], data[31:0], length[2:0]}.
  - head and tail are PTR_WIDTH bits wide and wrap modulo DEPTH.
  - count is PTR_WIDTH+1 bits wide.
- st_ready = (count < DEPTH), combinational from registered state. There is no same-cycle bypass when full, even if a pop occurs that cycle.
- Push happens when st_valid && st_ready && st_length is 1, 2 or 4.
  - The entry is written at tail, tail increments, count increments.
  - Illegal lengths (0, 3, 5–7) are dropped silently; no state changes.
- Drain:
  - w_req = (count != 0).
  - w_addr = head.addr + byte_idx, 32-bit wrap-around.
  - w_data = head.data[8*byte_idx +: 8].
- byte_idx is a 2-bit register and advances only on a clock edge where w_req && w_success.
  - If byte_idx+1 == head.length: pop (head increments, count decrements, byte_idx <= 0).
  - Otherwise: byte_idx <= byte_idx + 1.
- w_success while w_req=0 is ignored.
- Latency:
  - A push into an empty buffer raises w_req in the next cycle.
  - A store of length L needs exactly L cycles with w_success to retire.
- Simultaneous push and pop in the same cycle: count is unchanged, and both the head and tail pointers advance.
- empty = (count == 0), registered-state based.
- ld_conflict is combinational and asserted when ld_valid=1 and any valid entry's byte range [e.addr, e.addr+e.length) intersects [ld_addr, ld_addr+ld_length).
  - The intersection is evaluated with 33-bit sums, so no wrap aliasing occurs.
  - The check is conservative: it uses the full range of the head entry, including bytes already written.
  - When ld_valid=0, ld_conflict=0.
  - A store pushed in the same cycle is not included in the check. The MEM stage never presents a load and a store in the same cycle.
- The memory controller gives reads and fetches priority over writes, so w_success may stay low for arbitrary periods. w_req, w_addr and w_data must stay stable until accepted.

Test Plan:
- Reset, then one word store (addr 0x100, data 0xAABBCCDD, len 4), w_success held high → w_req rises one cycle after the push; bytes DD@0x100, CC@0x101, BB@0x102, AA@0x103 on consecutive cycles; empty=1 on the cycle after the last byte.
- Push 4 byte stores back-to-back with w_success=0 → st_ready=0 after the fourth push; a fifth st_valid is not accepted; releasing w_success drains them in FIFO order, and st_ready returns to 1 the cycle after the first pop.
- Half store (addr 0x200, data 0x1234, len 2) with w_success toggling 1,0,0,1 → outputs 0x34@0x200, held stable through both stalled cycles, then 0x12@0x201, then pop.
- Buffer holds word @0x300 → load (0x302, len 1) gives ld_conflict=1; load (0x304, len 4) gives 0; load (0x2FE, len 4) gives 1; ld_valid=0 gives 0.
- At full occupancy, drain the head's last byte while presenting a new store → no push that cycle (st_ready=0); on the next cycle the push is accepted and the tail wraps to slot 0.
- Assert reset mid-drain of a word after 2 bytes → next cycle w_req=0, empty=1, st_ready=1; a subsequent store drains starting at byte 0.

Source files
------------

// File: rtl/store_write_buffer.sv
// store_write_buffer: circular FIFO of committed stores, drained one byte per accepted
// cycle into the memory write port, with a conservative load-overlap hazard check.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_length,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_length,
  output logic        ld_conflict,
  output logic        empty,
  output logic        w_req,
  output logic [31:0] w_addr,
  output logic [7:0]  w_data,
  input  logic        w_success
);
  logic [31:0] r_addr [DEPTH];
  logic [31:0] r_data [DEPTH];
  logic [2:0]  r_len  [DEPTH];
  logic [PTR_WIDTH-1:0] r_head, r_tail;
  logic [PTR_WIDTH:0]   r_count;
  logic [1:0]           r_byte_idx;
  logic w_legal, w_push, w_adv, w_pop;
  logic [DEPTH-1:0] w_hit;
  assign st_ready = r_count < (PTR_WIDTH+1)'(DEPTH);
  assign empty    = r_count == '0;
  assign w_req    = !empty;
  assign w_addr   = r_addr[r_head] + {30'd0, r_byte_idx};
  assign w_data   = r_data[r_head][{r_byte_idx, 3'b000} +: 8];
  assign w_legal  = st_length == 3'd1 || st_length == 3'd2 || st_length == 3'd4;
  assign w_push   = st_valid && st_ready && w_legal;
  assign w_adv    = w_req && w_success;
  assign w_pop    = w_adv && ({1'b0, r_byte_idx} + 3'd1 == r_len[r_head]);
  // An entry is live when its distance from head is below count; ranges use 33-bit ends.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [PTR_WIDTH-1:0] w_off;
    assign w_off = PTR_WIDTH'(i) - r_head;
    assign w_hit[i] = ({1'b0, w_off} < r_count)
      && ({1'b0, r_addr[i]} < {1'b0, ld_addr} + {30'd0, ld_length})
      && ({1'b0, ld_addr} < {1'b0, r_addr[i]} + {30'd0, r_len[i]});
  end
  assign ld_conflict = ld_valid && |w_hit;
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
      r_len[r_tail]  <= st_length;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_byte_idx <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_WIDTH'(1);
      if (w_pop) r_head <= r_head + PTR_WIDTH'(1);
      if (w_adv) r_byte_idx <= w_pop ? 2'd0 : r_byte_idx + 2'd1;
      r_count <= r_count + (PTR_WIDTH+1)'(w_push) - (PTR_WIDTH+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the store buffer.
module tb_store_write_buffer;
  logic        clock = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_length;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_length;
  logic        ld_conflict, empty, w_req;
  logic [31:0] w_addr;
  logic [7:0]  w_data;
  logic        w_success;

  store_write_buffer #(.DEPTH(4), .PTR_WIDTH(2)) dut (
    .clock(clock), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_length(st_length),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_length(ld_length), .ld_conflict(ld_conflict),
    .empty(empty), .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_success(w_success)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] a; logic [31:0] d; int l; } ent_t;
  typedef struct {
    bit sv; logic [31:0] sa; logic [31:0] sd; logic [2:0] sl;
    bit lv; logic [31:0] la; logic [2:0] ll; bit ws;
    bit rdy; bit emp; bit req; logic [31:0] addr; logic [7:0] dat; bit conf;
  } vec_t;

  ent_t q[$];
  int bi = 0;
  int n_pass = 0, n_total = 0;
  vec_t tv[$];
  logic [2:0] lens [10] = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd0, 3'd3, 3'd5, 3'd7};

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  task automatic chk_model();
    bit c;
    c = 1'b0;
    chk("m_ready", 32'(st_ready), 32'(q.size() < 4));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_req", 32'(w_req), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_addr", w_addr, q[0].a + 32'(bi));
      chk("m_data", 32'(w_data), (q[0].d >> (8 * bi)) & 32'hff);
    end
    foreach (q[k])
      if (longint'(q[k].a) < longint'(ld_addr) + longint'(ld_length) &&
          longint'(ld_addr) < longint'(q[k].a) + longint'(q[k].l)) c = 1'b1;
    chk("m_conf", 32'(ld_conflict), 32'(c && ld_valid));
  endtask

  task automatic model_upd();
    bit pop, push;
    if (reset) begin
      q.delete();
      bi = 0;
    end else begin
      pop  = q.size() != 0 && w_success;
      push = st_valid && q.size() < 4 && (st_length == 1 || st_length == 2 || st_length == 4);
      if (pop) begin
        bi++;
        if (bi == q[0].l) begin
          void'(q.pop_front());
          bi = 0;
        end
      end
      if (push) q.push_back('{st_addr, st_data, int'(st_length)});
    end
  endtask

  task automatic finish_cyc();
    chk_model();
    @(posedge clock);
    model_upd();
    @(negedge clock);
  endtask

  task automatic cyc();
    #1;
    finish_cyc();
  endtask

  task automatic drv(bit sv, logic [31:0] sa, logic [31:0] sd, logic [2:0] sl,
                     bit lv, logic [31:0] la, logic [2:0] ll, bit ws);
    st_valid = sv; st_addr = sa; st_data = sd; st_length = sl;
    ld_valid = lv; ld_addr = la; ld_length = ll; w_success = ws;
  endtask

  initial begin
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0});
    tv.push_back('{1, 32'h100, 32'hAABBCCDD, 4, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h100, 8'hDD, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h101, 8'hCC, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h102, 8'hBB, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h103, 8'hAA, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0});
    tv.push_back('{1, 32'h200, 32'hFFFF1234, 2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h200, 8'h34, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h200, 8'h34, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h200, 8'h34, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h201, 8'h12, 0});
    tv.push_back('{1, 32'h500, 32'h99, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0});
    tv.push_back('{1, 32'h504, 32'h99, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0});
    tv.push_back('{1, 32'h300, 32'h11223344, 4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 1, 32'h302, 1, 0, 1, 0, 1, 32'h300, 8'h44, 1});
    tv.push_back('{0, 0, 0, 0, 1, 32'h304, 4, 0, 1, 0, 1, 32'h300, 8'h44, 0});
    tv.push_back('{0, 0, 0, 0, 1, 32'h2FE, 4, 0, 1, 0, 1, 32'h300, 8'h44, 1});
    tv.push_back('{0, 0, 0, 0, 0, 32'h302, 1, 0, 1, 0, 1, 32'h300, 8'h44, 0});
    tv.push_back('{0, 0, 0, 0, 1, 32'h2FC, 4, 0, 1, 0, 1, 32'h300, 8'h44, 0});
    tv.push_back('{0, 0, 0, 0, 1, 32'h303, 2, 1, 1, 0, 1, 32'h300, 8'h44, 1});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h301, 8'h33, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h302, 8'h22, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h303, 8'h11, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0});

    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    model_upd();
    @(negedge clock);
    reset = 1'b0;

    foreach (tv[r]) begin
      drv(tv[r].sv, tv[r].sa, tv[r].sd, tv[r].sl, tv[r].lv, tv[r].la, tv[r].ll, tv[r].ws);
      #1;
      chk($sformatf("t%0d_ready", r), 32'(st_ready), 32'(tv[r].rdy));
      chk($sformatf("t%0d_empty", r), 32'(empty), 32'(tv[r].emp));
      chk($sformatf("t%0d_req", r), 32'(w_req), 32'(tv[r].req));
      chk($sformatf("t%0d_conf", r), 32'(ld_conflict), 32'(tv[r].conf));
      if (tv[r].req) begin
        chk($sformatf("t%0d_addr", r), w_addr, tv[r].addr);
        chk($sformatf("t%0d_data", r), 32'(w_data), 32'(tv[r].dat));
      end
      finish_cyc();
    end

    // Fill with w_success low, fifth store refused, then FIFO-order drain.
    for (int i = 0; i < 4; i++) begin
      drv(1, 32'h10 + i, 32'hA0 + i, 1, 0, 0, 0, 0);
      cyc();
    end
    drv(1, 32'h99, 32'h99, 1, 0, 0, 0, 0);
    #1;
    chk("full_ready", 32'(st_ready), 0);
    finish_cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_data", 32'(w_data), 32'hA0 + i);
      chk("fill_addr", w_addr, 32'h10 + i);
      if (i == 0) chk("ready_during_pop", 32'(st_ready), 0);
      if (i == 1) chk("ready_after_pop", 32'(st_ready), 1);
      finish_cyc();
    end
    #1;
    chk("fill_empty", 32'(empty), 1);
    finish_cyc();

    // Full buffer: push presented while head pops is refused, accepted next cycle.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1, 32'h20 + i, 32'hB0 + i, 1, 0, 0, 0, 0);
      cyc();
    end
    drv(1, 32'h40, 32'hC5, 1, 0, 0, 0, 1);
    #1;
    chk("wrap_ready0", 32'(st_ready), 0);
    finish_cyc();
    #1;
    chk("wrap_ready1", 32'(st_ready), 1);
    chk("wrap_data1", 32'(w_data), 32'hB1);
    finish_cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wrap_drain", 32'(w_data), i == 2 ? 32'hC5 : 32'hB2 + i);
      finish_cyc();
    end
    #1;
    chk("wrap_empty", 32'(empty), 1);
    finish_cyc();

    // Reset in the middle of draining a word.
    drv(1, 32'h600, 32'h55667788, 4, 0, 0, 0, 1);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_req", 32'(w_req), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ready", 32'(st_ready), 1);
    finish_cyc();
    drv(1, 32'h700, 32'h04030201, 4, 0, 0, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rst_first_addr", w_addr, 32'h700);
    chk("rst_first_data", 32'(w_data), 32'h01);
    finish_cyc();

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      int s;
      s = $urandom_range(0, 3);
      a = s < 2 ? 32'h1000 + $urandom_range(0, 12) : s == 2 ? 32'hFFFFFFFC + $urandom_range(0, 3) : $urandom;
      reset = $urandom_range(0, 63) == 0;
      if ($urandom_range(0, 1) == 1)
        drv(1, a, $urandom, lens[$urandom_range(0, 9)], 0, 0, 1, $urandom_range(0, 1) == 1);
      else
        drv(0, 0, 0, 0, $urandom_range(0, 3) != 0, a, lens[$urandom_range(0, 2)], $urandom_range(0, 1) == 1);
      cyc();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
